// File: rtl/elevator_pkg.sv
// elevator_pkg: definitions shared by the hall-call registrar and its sub-blocks.
//   DIR_UP / DIR_DOWN  - encoding of the up_ndown direction bit.
//   floor_t            - floor index for the default 8-floor building.
//   hall_call_t        - {floor, up_ndown} pair describing one hall call.
//   dispatch_state_t   - states of the dispatcher-offer FSM.
//   dir_legal()        - rejects the impossible directions at the end floors.
`timescale 1ns/1ps
package elevator_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEF_NUM_FLOORS = 8;
    localparam int DEF_FLOOR_W    = $clog2(DEF_NUM_FLOORS);

    typedef logic [DEF_FLOOR_W-1:0] floor_t;

    typedef struct packed {
        floor_t floor;
        logic   up_ndown;
    } hall_call_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_OFFER = 2'd2
    } dispatch_state_t;

    // The bottom floor can only call up and the top floor can only call down.
    function automatic logic dir_legal(input int floor_idx, input int num_floors,
                                       input logic up_ndown);
        logic ok;
        if (floor_idx == 0) begin
            ok = (up_ndown == DIR_UP);
        end else if (floor_idx == num_floors - 1) begin
            ok = (up_ndown == DIR_DOWN);
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/hall_input_sync.sv
// hall_input_sync: brings one floor's button-panel request/direction pair into the
// clk domain and flags the request's rising edge.
//   clk, reset  - system clock, asynchronous active-low reset
//   req_async   - request level from the panel (asynchronous)
//   dir_async   - direction level from the panel (asynchronous)
//   rise        - one-cycle pulse on the synchronized request's rising edge
//   dir         - synchronized direction, aligned with rise
`timescale 1ns/1ps
module hall_input_sync (
    input  logic clk,
    input  logic reset,
    input  logic req_async,
    input  logic dir_async,
    output logic rise,
    output logic dir
);

    logic req_meta_r;
    logic req_sync_r;
    logic req_prev_r;
    logic dir_meta_r;
    logic dir_sync_r;

    // Two-flop synchronizers for request and direction plus the edge-history flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_meta_r <= 1'b0;
            req_sync_r <= 1'b0;
            req_prev_r <= 1'b0;
            dir_meta_r <= 1'b0;
            dir_sync_r <= 1'b0;
        end else begin
            req_meta_r <= req_async;
            req_sync_r <= req_meta_r;
            req_prev_r <= req_sync_r;
            dir_meta_r <= dir_async;
            dir_sync_r <= dir_meta_r;
        end
    end

    assign rise = req_sync_r & ~req_prev_r;
    assign dir  = dir_sync_r;

endmodule

// File: rtl/hall_call_registrar.sv
// hall_call_registrar: registers hall calls from every floor, acknowledges them,
// drives the direction lamps and offers unassigned calls round-robin to the car
// dispatcher over a valid/ready handshake. Car service reports clear calls.
//   clk, reset                       - system clock, asynchronous active-low reset
//   hall_request / hall_up_ndown     - per-floor panel request and direction (async)
//   hall_ack                         - per-floor one-cycle acknowledge
//   lamp_up / lamp_down              - per-floor pending-call lamps
//   service_valid/_floor/_up_ndown   - car reports a call serviced
//   call_valid/_floor/_up_ndown      - call offered to the dispatcher
//   call_ready                       - dispatcher accepts the offered call
// Calls live in slots indexed 2*floor + up_ndown.
`timescale 1ns/1ps
module hall_call_registrar
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] hall_request,
    input  logic [NUM_FLOORS-1:0] hall_up_ndown,
    output logic [NUM_FLOORS-1:0] hall_ack,
    output logic [NUM_FLOORS-1:0] lamp_up,
    output logic [NUM_FLOORS-1:0] lamp_down,
    input  logic                  service_valid,
    input  logic [FLOOR_W-1:0]    service_floor,
    input  logic                  service_up_ndown,
    output logic                  call_valid,
    output logic [FLOOR_W-1:0]    call_floor,
    output logic                  call_up_ndown,
    input  logic                  call_ready
);

    localparam int NUM_SLOTS = 2 * NUM_FLOORS;
    localparam int SLOT_W    = FLOOR_W + 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    logic [NUM_FLOORS-1:0] rise_s;
    logic [NUM_FLOORS-1:0] dir_s;
    logic [NUM_FLOORS-1:0] evt_legal_s;
    logic [NUM_FLOORS-1:0] svc_hit_s;
    logic [NUM_SLOTS-1:0]  set_mask_s;
    logic [NUM_SLOTS-1:0]  clr_mask_s;
    logic [NUM_SLOTS-1:0]  assign_mask_s;
    logic [NUM_SLOTS-1:0]  pending_next_s;
    logic [NUM_SLOTS-1:0]  assigned_next_s;
    logic [NUM_SLOTS-1:0]  avail_s;
    logic [NUM_FLOORS-1:0] lamp_up_next_s;
    logic [NUM_FLOORS-1:0] lamp_down_next_s;
    logic                  any_avail_s;
    logic                  ptr_hit_s;
    logic                  handshake_s;
    logic                  off_drop_s;
    logic [SLOT_W-1:0]     off_slot_s;
    logic [SLOT_W-1:0]     ptr_plus1_s;
    logic [SLOT_W-1:0]     off_plus1_s;
    logic [SLOT_W-1:0]     ptr_next_s;
    dispatch_state_t       state_next_s;
    logic                  call_valid_next_s;
    logic [FLOOR_W-1:0]    call_floor_next_s;
    logic                  call_up_next_s;

    logic [NUM_SLOTS-1:0]  pending_r;
    logic [NUM_SLOTS-1:0]  assigned_r;
    logic [NUM_FLOORS-1:0] hall_ack_r;
    logic [NUM_FLOORS-1:0] lamp_up_r;
    logic [NUM_FLOORS-1:0] lamp_down_r;
    logic [SLOT_W-1:0]     ptr_r;
    dispatch_state_t       state_r;
    logic                  call_valid_r;
    logic [FLOOR_W-1:0]    call_floor_r;
    logic                  call_up_r;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : gen_sync
        hall_input_sync u_sync (
            .clk       (clk),
            .reset     (reset),
            .req_async (hall_request[g]),
            .dir_async (hall_up_ndown[g]),
            .rise      (rise_s[g]),
            .dir       (dir_s[g])
        );
    end

    // Per-slot set (legal new call) and clear (service report) masks; an
    // out-of-range service floor matches no slot and is therefore ignored.
    always_comb begin
        evt_legal_s      = '0;
        svc_hit_s        = '0;
        set_mask_s       = '0;
        clr_mask_s       = '0;
        lamp_up_next_s   = '0;
        lamp_down_next_s = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            evt_legal_s[f]      = rise_s[f] & dir_legal(f, NUM_FLOORS, dir_s[f]);
            set_mask_s[2*f+1]   = evt_legal_s[f] & dir_s[f];
            set_mask_s[2*f]     = evt_legal_s[f] & ~dir_s[f];
            svc_hit_s[f]        = service_valid & (service_floor == FLOOR_W'(f));
            clr_mask_s[2*f+1]   = svc_hit_s[f] & service_up_ndown;
            clr_mask_s[2*f]     = svc_hit_s[f] & ~service_up_ndown;
            lamp_up_next_s[f]   = pending_next_s[2*f+1];
            lamp_down_next_s[f] = pending_next_s[2*f];
        end
    end

    // Clear has priority over a simultaneous set; duplicates leave state unchanged.
    assign pending_next_s  = (pending_r | set_mask_s) & ~clr_mask_s;
    assign assigned_next_s = (assigned_r | assign_mask_s) & ~clr_mask_s;

    // A slot being cleared this cycle is never picked for an offer.
    assign avail_s     = pending_r & ~assigned_r & ~clr_mask_s;
    assign any_avail_s = |avail_s;
    assign ptr_hit_s   = avail_s[ptr_r];
    assign off_slot_s  = {call_floor_r, call_up_r};
    assign ptr_plus1_s = (ptr_r == LAST_SLOT) ? {SLOT_W{1'b0}} : ptr_r + SLOT_W'(1);
    assign off_plus1_s = (off_slot_s == LAST_SLOT) ? {SLOT_W{1'b0}} : off_slot_s + SLOT_W'(1);
    assign handshake_s = (state_r == ST_OFFER) & call_valid_r & call_ready;
    assign off_drop_s  = (state_r == ST_OFFER) & (clr_mask_s[off_slot_s] | ~pending_r[off_slot_s]);

    // Call bookkeeping, acknowledge pulses and lamp registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r   <= '0;
            assigned_r  <= '0;
            hall_ack_r  <= '0;
            lamp_up_r   <= '0;
            lamp_down_r <= '0;
        end else begin
            pending_r   <= pending_next_s;
            assigned_r  <= assigned_next_s;
            hall_ack_r  <= evt_legal_s;
            lamp_up_r   <= lamp_up_next_s;
            lamp_down_r <= lamp_down_next_s;
        end
    end

    // Dispatch FSM state and scan pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
        end
    end

    // Dispatch FSM next-state and pointer advance.
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (any_avail_s) begin
                    state_next_s = ST_SCAN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!any_avail_s) begin
                    state_next_s = ST_IDLE;
                end else if (ptr_hit_s) begin
                    state_next_s = ST_OFFER;
                end else begin
                    ptr_next_s = ptr_plus1_s;
                end
            end
            ST_OFFER: begin
                if (handshake_s || off_drop_s) begin
                    state_next_s = ST_SCAN;
                    ptr_next_s   = off_plus1_s;
                end else begin
                    state_next_s = ST_OFFER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                ptr_next_s   = '0;
            end
        endcase
    end

    // Dispatch FSM outputs: next offer fields and the assigned-bit update.
    always_comb begin
        call_valid_next_s = 1'b0;
        call_floor_next_s = call_floor_r;
        call_up_next_s    = call_up_r;
        assign_mask_s     = '0;
        case (state_r)
            ST_SCAN: begin
                if (any_avail_s && ptr_hit_s) begin
                    call_valid_next_s = 1'b1;
                    call_floor_next_s = ptr_r[SLOT_W-1:1];
                    call_up_next_s    = ptr_r[0];
                end else begin
                    call_valid_next_s = 1'b0;
                end
            end
            ST_OFFER: begin
                if (handshake_s) begin
                    assign_mask_s[off_slot_s] = 1'b1;
                    call_valid_next_s         = 1'b0;
                end else if (off_drop_s) begin
                    call_valid_next_s = 1'b0;
                end else begin
                    call_valid_next_s = 1'b1;
                end
            end
            default: begin
                call_valid_next_s = 1'b0;
            end
        endcase
    end

    // Registered offer outputs toward the dispatcher.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            call_valid_r <= 1'b0;
            call_floor_r <= '0;
            call_up_r    <= 1'b0;
        end else begin
            call_valid_r <= call_valid_next_s;
            call_floor_r <= call_floor_next_s;
            call_up_r    <= call_up_next_s;
        end
    end

    assign hall_ack      = hall_ack_r;
    assign lamp_up       = lamp_up_r;
    assign lamp_down     = lamp_down_r;
    assign call_valid    = call_valid_r;
    assign call_floor    = call_floor_r;
    assign call_up_ndown = call_up_r;

endmodule
